stream_rr_arbiter: RTL and testbench
====================================

# stream_rr_arbiter

Round-robin arbiter that merges `n_req` valid/ready upstream streams into one downstream stream through a single registered output stage. It shares one adder-FIFO datapath, such as the two-operand stream summing block with FIFOs, between several independent producers. Each output beat carries the index of the requester that supplied it.

## Interface
Parameters:
- `width`, 4, data width of every stream
- `n_req`, 4, number of upstream requesters; legal range 2..16
- `id_w`, `$clog2(n_req)`, width of the requester index (localparam)

Ports:
- `clk`  in  1  clock; all logic on posedge
- `rst`  in  1  reset; one clock, synchronous, active-high
- `in_valid`  in  `n_req`  per-requester valid
- `in_ready`  out  `n_req`  per-requester ready
- `in_data`  in  `n_req*width`  requester i occupies bits `[i*width +: width]`
- `in_last`  in  `n_req`  per-requester end-of-packet; ignored unless `STREAM_ARB_LAST_LOCK_EN` is defined
- `out_valid`  out  1  downstream valid, registered
- `out_ready`  in  1  downstream ready
- `out_data`  out  `width`  downstream data, registered
- `out_last`  out  1  copy of the accepted `in_last`, registered
- `out_id`  out  `id_w`  index of the requester that supplied the beat, registered

## Operation
- State registers:
  - Output stage: `out_valid`, `out_data`, `out_last`, `out_id`.
  - Priority pointer `ptr` (`id_w` bits).
  - Lock state `lock`, `lock_id` (macro only).
- Stage can load when `load_ok = ~out_valid | out_ready`.
- Grant (combinational):
  - Scan requesters starting at `ptr`, wrapping modulo `n_req`.
  - The first requester with `in_valid` set is granted.
  - There is at most one grant.
- `in_ready[i] = grant[i] & load_ok & ~rst`. Non-granted requesters always see `in_ready` = 0.
- On an accepted transfer (`in_valid[g] & in_ready[g]`):
  - Load the stage with data, last and id `g`; set `out_valid` = 1.
  - Set `ptr` = (g+1) mod `n_req`, with explicit wrap when `n_req` is not a power of two.
- Downstream handshake with no new load: `out_valid` = 0.
- Simultaneous downstream handshake and new load: the stage is overwritten in the same cycle, giving full throughput of 1 beat per cycle.
- `out_valid` never depends combinationally on `out_ready`.
- `in_ready` may depend on `in_valid` of other requesters.
- No valid requesters: no grant, `ptr` is unchanged.
- Reset mid-packet or mid-transfer: the stage content is discarded, `out_valid` = 0, and lock is cleared.

## Timing
- Reset values: `out_valid` 0, `out_data` 0, `out_last` 0, `out_id` 0, `ptr` 0, `lock` 0. `in_ready` is all 0 while `rst` = 1.
- Latency: a beat accepted at edge N appears on `out_*` from edge N (visible in cycle N+1) and holds until `out_ready` is sampled high.
- Fairness: with all requesters continuously valid and `out_ready` = 1, grants rotate 0,1,...,`n_req`-1,0,... with one beat each per cycle.
- Under backpressure (`out_ready` = 0 with `out_valid` = 1): all `in_ready` = 0, and `ptr` and the output registers hold.

## Configuration
- `STREAM_ARB_LAST_LOCK_EN` defined: packet lock is enabled.
  - An accepted beat with `in_last` = 0 sets `lock` = 1 and `lock_id` = g.
  - While locked, only `lock_id` may be granted, whatever `ptr` and the other `in_valid` are.
  - An accepted beat with `in_last` = 1 clears `lock`.
  - `ptr` advances only on the `last` beat.
- Not defined: every beat is arbitrated independently.
  - `in_last` is ignored for grant decisions but still forwarded to `out_last`.
  - No lock registers are built.

## Test plan
- Reset then idle: after 3 cycles of `rst`, all outputs are 0 and `in_ready` = 0000; with all `in_valid` = 0 the outputs stay 0.
- Back-to-back fairness (`n_req` 4): all valid, `out_ready` = 1 for 8 cycles.
  - Required: `out_id` sequence 0,1,2,3,0,1,2,3, with data matching each requester's queue in order.
- Sparse requesters: only 1 and 3 valid, `ptr` starting at 0.
  - Required: `out_id` alternates 1,3,1,3; `in_ready[0]` and `in_ready[2]` are never 1.
- Backpressure: `out_ready` = 0 for 10 cycles with all valid.
  - Required: exactly one beat is accepted and holds stable on `out_*`.
  - After release, the next `out_id` = (held id + 1) mod 4; no beat is lost or duplicated versus the per-requester scoreboard queues.
- Packet lock (macro defined): requester 2 sends beats with last = 0,0,1 while 0, 1 and 3 are valid.
  - Required: `out_id` = 2,2,2, then 3.
  - Without the macro the same stimulus yields 2,3,0,1.
- Random: 200 cycles of random `in_valid`, `in_last`, `out_ready`, followed by a drain.
  - Scoreboard per-id queues must be empty at the end.
  - `out_*` must stay stable while `out_valid & ~out_ready`.

Source files
------------

// File: rtl/stream_rr_arbiter.sv
// Round-robin valid/ready arbiter with a single registered output stage.
// Optional packet lock on in_last when STREAM_ARB_LAST_LOCK_EN is defined.
module stream_rr_arbiter #(
   parameter int width = 4,
   parameter int n_req = 4,
   localparam int id_w = $clog2(n_req)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [n_req-1:0]       in_valid,
   output logic [n_req-1:0]       in_ready,
   input  logic [n_req*width-1:0] in_data,
   input  logic [n_req-1:0]       in_last,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [width-1:0]       out_data,
   output logic                   out_last,
   output logic [id_w-1:0]        out_id
);

   localparam int sw = id_w + 1;

   logic [id_w-1:0]  ptr;
   logic [id_w-1:0]  gid;
   logic [id_w-1:0]  next_ptr;
   logic [sw-1:0]    idx;
   logic             found;
   logic             load_ok;
   logic             accept;
   logic [n_req-1:0] grant;
   logic [width-1:0] sel_data;
   logic             sel_last;

`ifdef STREAM_ARB_LAST_LOCK_EN
   logic             lock;
   logic [id_w-1:0]  lock_id;
`endif

   assign load_ok = ~out_valid | out_ready;

   // Scan from ptr with explicit modulo wrap so non-power-of-two n_req works.
   always_comb begin
      found = 1'b0;
      gid   = '0;
      idx   = '0;
      for (int unsigned k = 0; k < n_req; k++) begin
         idx = {1'b0, ptr} + sw'(k);
         if (idx >= sw'(n_req))
            idx = idx - sw'(n_req);
         if (!found && in_valid[idx[id_w-1:0]]) begin
            found = 1'b1;
            gid   = idx[id_w-1:0];
         end
      end
`ifdef STREAM_ARB_LAST_LOCK_EN
      if (lock) begin
         found = in_valid[lock_id];
         gid   = lock_id;
      end
`endif
   end

   always_comb begin
      grant    = '0;
      sel_data = '0;
      if (found)
         grant[gid] = 1'b1;
      for (int unsigned i = 0; i < n_req; i++) begin
         if (gid == id_w'(i))
            sel_data = in_data[i*width +: width];
      end
   end

   assign sel_last = in_last[gid];
   assign in_ready = grant & {n_req{load_ok & ~rst}};
   assign accept   = found & load_ok & ~rst;
   assign next_ptr = (gid == id_w'(n_req - 1)) ? '0 : gid + 1'b1;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_last  <= 1'b0;
         out_id    <= '0;
         ptr       <= '0;
`ifdef STREAM_ARB_LAST_LOCK_EN
         lock      <= 1'b0;
         lock_id   <= '0;
`endif
      end else begin
         if (accept) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
            out_last  <= sel_last;
            out_id    <= gid;
`ifdef STREAM_ARB_LAST_LOCK_EN
            lock      <= ~sel_last;
            lock_id   <= gid;
            if (sel_last)
               ptr <= next_ptr;
`else
            ptr       <= next_ptr;
`endif
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Self-checking bench for stream_rr_arbiter (n_req 4, width 4): directed vector
// table, packet-lock sequence, random traffic with per-requester scoreboard.
module tb_stream_rr_arbiter;

   localparam int W = 4;
   localparam int N = 4;

   logic          clk;
   logic          rst;
   logic [N-1:0]  in_valid;
   logic [N-1:0]  in_ready;
   logic [N*W-1:0] in_data;
   logic [N-1:0]  in_last;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_data;
   logic          out_last;
   logic [1:0]    out_id;

   stream_rr_arbiter #(.width(W), .n_req(N)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_last(out_last), .out_id(out_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  valid;
      logic [15:0] data;
      logic [3:0]  last;
      logic        ordy;
      logic [3:0]  erdy;
      logic        eov;
      logic [1:0]  eid;
      logic [3:0]  edata;
      logic        elast;
   } vec_t;

   vec_t tab[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   logic [4:0] sbq[N][$];
   logic       hold_prev = 1'b0;
   logic [7:0] held = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic [3:0] v, input logic [15:0] d, input logic [3:0] l,
                               input logic r, input logic [3:0] er, input logic eov,
                               input logic [1:0] eid, input logic [3:0] ed, input logic el);
      vec_t t;
      t.valid = v;  t.data = d;   t.last = l;  t.ordy = r;
      t.erdy = er;  t.eov = eov;  t.eid = eid; t.edata = ed; t.elast = el;
      return t;
   endfunction

   task automatic apply(input vec_t v);
      @(negedge clk);
      in_valid = v.valid; in_data = v.data; in_last = v.last; out_ready = v.ordy;
      #1;
      chk("tab_in_ready", 32'(in_ready), 32'(v.erdy));
      @(posedge clk);
      #1;
      chk("tab_out_valid", 32'(out_valid), 32'(v.eov));
      chk("tab_out_id",    32'(out_id),    32'(v.eid));
      chk("tab_out_data",  32'(out_data),  32'(v.edata));
      chk("tab_out_last",  32'(out_last),  32'(v.elast));
   endtask

   // Called mid-cycle; inputs and DUT state match what the next posedge samples.
   task automatic mon();
      logic [4:0] e;
      if (hold_prev) begin
         chk("hold_valid", 32'(out_valid), 32'd1);
         chk("hold_beat", 32'({out_id, out_last, out_data}), 32'(held[6:0]));
      end
      chk("one_hot", 32'($countones(in_ready) > 1), 32'd0);
      chk("ready_wo_valid", 32'(in_ready & ~in_valid), 32'd0);
      for (int i = 0; i < N; i++)
         if (in_valid[i] && in_ready[i])
            sbq[i].push_back({in_last[i], in_data[i*W +: W]});
      if (out_valid && out_ready) begin
         if (sbq[out_id].size() == 0) begin
            chk("sb_unexpected", 32'(out_id), 32'hFF);
         end else begin
            e = sbq[out_id].pop_front();
            chk("sb_beat", 32'({out_last, out_data}), 32'(e));
         end
      end
      hold_prev = out_valid & ~out_ready;
      held = {1'b0, out_id, out_last, out_data};
   endtask

   logic [3:0]  lk_valid[5];
   logic [3:0]  lk_last[5];
   logic [1:0]  lk_id[5];
   logic        lk_elast[5];

   initial begin
      rst = 1'b1; in_valid = 4'hF; in_data = '0; in_last = '0; out_ready = 1'b1;

      // reset: in_ready held low even with all valid
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready",  32'(in_ready),  32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_data",  32'(out_data),  32'd0);
      chk("rst_out_last",  32'(out_last),  32'd0);
      chk("rst_out_id",    32'(out_id),    32'd0);
      @(negedge clk);
      rst = 1'b0; in_valid = '0;

      tab.push_back(mk(4'h0, 16'h0000, 4'hF, 1'b1, 4'b0000, 1'b0, 2'd0, 4'h0, 1'b0));
      tab.push_back(mk(4'h0, 16'h0000, 4'hF, 1'b0, 4'b0000, 1'b0, 2'd0, 4'h0, 1'b0));
      for (int r = 0; r < 2; r++) begin
         tab.push_back(mk(4'hF, 16'h4321, 4'hF, 1'b1, 4'b0001, 1'b1, 2'd0, 4'h1, 1'b1));
         tab.push_back(mk(4'hF, 16'h8765, 4'hF, 1'b1, 4'b0010, 1'b1, 2'd1, 4'h6, 1'b1));
         tab.push_back(mk(4'hF, 16'hCBA9, 4'hF, 1'b1, 4'b0100, 1'b1, 2'd2, 4'hB, 1'b1));
         tab.push_back(mk(4'hF, 16'h0FED, 4'hF, 1'b1, 4'b1000, 1'b1, 2'd3, 4'h0, 1'b1));
      end
      for (int r = 0; r < 2; r++) begin
         tab.push_back(mk(4'b1010, 16'h7050, 4'hF, 1'b1, 4'b0010, 1'b1, 2'd1, 4'h5, 1'b1));
         tab.push_back(mk(4'b1010, 16'h7050, 4'hF, 1'b1, 4'b1000, 1'b1, 2'd3, 4'h7, 1'b1));
      end
      tab.push_back(mk(4'h0, 16'h0000, 4'hF, 1'b1, 4'b0000, 1'b0, 2'd3, 4'h7, 1'b1));
      tab.push_back(mk(4'h0, 16'h0000, 4'hF, 1'b0, 4'b0000, 1'b0, 2'd3, 4'h7, 1'b1));
      // backpressure: one beat in, ten stalled cycles, then release
      tab.push_back(mk(4'hF, 16'h4321, 4'hF, 1'b0, 4'b0001, 1'b1, 2'd0, 4'h1, 1'b1));
      for (int r = 0; r < 10; r++)
         tab.push_back(mk(4'hF, 16'h8765, 4'hF, 1'b0, 4'b0000, 1'b1, 2'd0, 4'h1, 1'b1));
      tab.push_back(mk(4'hF, 16'h8765, 4'hF, 1'b1, 4'b0010, 1'b1, 2'd1, 4'h6, 1'b1));
      tab.push_back(mk(4'h0, 16'h0000, 4'hF, 1'b1, 4'b0000, 1'b0, 2'd1, 4'h6, 1'b1));

      foreach (tab[i]) apply(tab[i]);

      // packet lock: ptr is 2 here; requester 2 sends last 0,0,1
      lk_valid = '{4'hF, 4'hF, 4'hF, 4'hF, 4'b1000};
      lk_last  = '{4'b0000, 4'b0000, 4'b0100, 4'b0000, 4'b1000};
`ifdef STREAM_ARB_LAST_LOCK_EN
      lk_id    = '{2'd2, 2'd2, 2'd2, 2'd3, 2'd3};
      lk_elast = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
`else
      lk_id    = '{2'd2, 2'd3, 2'd0, 2'd1, 2'd3};
      lk_elast = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`endif
      for (int b = 0; b < 5; b++) begin
         @(negedge clk);
         in_valid = lk_valid[b]; in_last = lk_last[b]; in_data = 16'hDCBA; out_ready = 1'b1;
         #1;
         chk("lock_in_ready", 32'(in_ready), 32'(4'b0001 << lk_id[b]));
         @(posedge clk);
         #1;
         chk("lock_out_valid", 32'(out_valid), 32'd1);
         chk("lock_out_id",    32'(out_id),    32'(lk_id[b]));
         chk("lock_out_data",  32'(out_data),  32'(4'hA + 4'(lk_id[b])));
         chk("lock_out_last",  32'(out_last),  32'(lk_elast[b]));
      end
      @(negedge clk);
      in_valid = '0;
      @(posedge clk);
      #1;
      chk("lock_drain", 32'(out_valid), 32'd0);

      // random traffic with scoreboard
      hold_prev = 1'b0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         in_valid  = 4'($urandom);
         in_last   = 4'($urandom);
         in_data   = 16'($urandom);
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         mon();
      end
      begin
         int t = 0;
         do begin
            @(negedge clk);
            in_valid = '0; out_ready = 1'b1;
            #1;
            mon();
            t++;
         end while (out_valid && t < 20);
      end
      chk("drain_timeout", 32'(out_valid), 32'd0);
      for (int i = 0; i < N; i++)
         chk("sb_empty", 32'(sbq[i].size()), 32'd0);

      // reset while a beat is held in the stage
      @(negedge clk);
      in_valid = 4'hF; in_last = 4'hF; in_data = 16'h4321; out_ready = 1'b0;
      @(posedge clk);
      #1;
      chk("mid_loaded", 32'(out_valid), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("mid_rst_in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_beat", 32'({out_id, out_last, out_data}), 32'd0);
      @(negedge clk);
      rst = 1'b0; out_ready = 1'b1;
      #1;
      chk("post_rst_in_ready", 32'(in_ready), 32'b0001);
      @(posedge clk);
      #1;
      chk("post_rst_id", 32'({out_valid, out_id}), 32'b100);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
      $finish;
   end

endmodule
